// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC generation, one-outstanding icache reads,
// a small tagged instruction FIFO toward decode, and redirect/flush handling.

package if_stage_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } icache_out_t;

  typedef struct packed {
    icache_out_t        data;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     DEPTH   = 4,
  parameter logic [XLEN-1:0] BOOT_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic [XLEN-1:0]   fetch_pc_o,
  output logic              read_req_o,
  input  icache_out_t       cache_out_i,
  input  logic              read_done_i,
  output logic              flush_o,
  output icache_out_t       dec_instr_o,
  output logic [XLEN-1:0]   dec_pc_o,
  output logic              dec_valid_o,
  input  logic              dec_ready_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [XLEN-1:0]    pc;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       mem [DEPTH];
  fetch_entry_t       head;
  logic               full;
  logic               push;
  logic               pop;
  logic               unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  assign full        = (count == CNT_W'(DEPTH));
  assign head        = mem[rd_ptr];
  assign fetch_pc_o  = pc;
  assign flush_o     = redirect_i;
  assign dec_valid_o = (count != '0);
  assign dec_instr_o = head.data;
  assign dec_pc_o    = head.pc;
  // Redirect discards the head, so a coincident pop is not honoured.
  assign pop         = dec_valid_o && dec_ready_i && !redirect_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_START;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redirect overrides everything and abandons any request
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_START: state_nxt = S_IDLE;
      S_IDLE:  if (read_req_o) state_nxt = S_WAIT;
      S_WAIT:  if (read_done_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (redirect_i) begin
      state_nxt = S_IDLE;
    end
  end

  // Output logic: issue only with FIFO room, accept data only while waiting
  always_comb begin
    read_req_o = 1'b0;
    push       = 1'b0;
    unique case (state)
      S_IDLE:  read_req_o = !full && !redirect_i;
      S_WAIT:  push       = read_done_i && !redirect_i;
      default: ;
    endcase
  end

  // PC and instruction FIFO
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc     <= BOOT_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (redirect_i) begin
      pc     <= {redirect_pc_i[XLEN-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: cache_out_i, pc: pc};
        wr_ptr      <= wr_ptr + PTR_W'(1);
        pc          <= pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Issue gating should make this impossible; catch it if it ever happens.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a timed icache responder, a queue-based fetch model,
// a reset-sequence vector table, directed corner cases and a random phase.

module tb_if_stage;
  import if_stage_pkg::*;

  localparam int unsigned     DEPTH = 4;
  localparam logic [XLEN-1:0] BOOT  = 32'h100;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic [XLEN-1:0]  fetch_pc_o;
  logic             read_req_o;
  icache_out_t      cache_out_i;
  logic             read_done_i;
  logic             flush_o;
  icache_out_t      dec_instr_o;
  logic [XLEN-1:0]  dec_pc_o;
  logic             dec_valid_o;
  logic             dec_ready_i;

  if_stage #(.DEPTH(DEPTH), .BOOT_PC(BOOT)) dut (
    .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_pc_o(fetch_pc_o), .read_req_o(read_req_o), .cache_out_i(cache_out_i),
    .read_done_i(read_done_i), .flush_o(flush_o), .dec_instr_o(dec_instr_o),
    .dec_pc_o(dec_pc_o), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    icache_out_t     data;
  } exp_t;

  typedef struct {
    bit              ready;
    bit              req;
    logic [XLEN-1:0] pc;
    bit              valid;
    logic [XLEN-1:0] dpc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: fetched-but-unconsumed words, next PC, one-outstanding flag
  exp_t            q[$];
  logic [XLEN-1:0] m_pc;
  bit              m_out;
  bit              m_start;
  bit              exp_req;

  // icache responder
  bit resp_busy;
  int resp_cnt;
  int lat = 2;
  bit inject_done;
  int n_req;
  logic [XLEN-1:0] last_req_pc;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit done_next();
    return resp_busy && resp_cnt == 0;
  endfunction

  // Drive the responder's inputs for this cycle and let outputs settle.
  task automatic settle();
    bit done;
    done = 1'b0;
    if (inject_done) begin
      done = 1'b1;
      inject_done = 1'b0;
    end else if (resp_busy) begin
      if (resp_cnt == 0) begin
        done = 1'b1;
        resp_busy = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    read_done_i = done;
    cache_out_i = '{instr: 32'($urandom), fault: 1'($urandom)};
    #1;
  endtask

  // Compare against the model, then apply this cycle's effects and cross the edge.
  task automatic advance();
    exp_req = !m_start && !m_out && (q.size() < DEPTH) && !redirect_i;
    check("read_req", 64'(read_req_o), 64'(exp_req));
    check("flush", 64'(flush_o), 64'(redirect_i));
    check("fetch_pc", 64'(fetch_pc_o), 64'(m_pc));
    check("dec_valid", 64'(dec_valid_o), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("dec_pc", 64'(dec_pc_o), 64'(q[0].pc));
      check("dec_instr", 64'(dec_instr_o), 64'(q[0].data));
    end
    if (read_req_o) begin
      n_req++;
      last_req_pc = fetch_pc_o;
    end
    if (redirect_i) begin
      q.delete();
      m_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
      m_out     = 1'b0;
      resp_busy = 1'b0;
    end else begin
      if (q.size() != 0 && dec_ready_i) void'(q.pop_front());
      if (m_out && read_done_i) begin
        q.push_back('{pc: m_pc, data: cache_out_i});
        m_pc  = m_pc + 32'd4;
        m_out = 1'b0;
      end else if (exp_req) begin
        m_out = 1'b1;
      end
    end
    m_start = 1'b0;
    if (read_req_o && !redirect_i) begin
      resp_busy = 1'b1;
      resp_cnt  = lat - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic do_reset();
    redirect_i = 1'b0;
    read_done_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rst_valid", 64'(dec_valid_o), 64'(0));
    check("rst_req", 64'(read_req_o), 64'(0));
    check("rst_flush", 64'(flush_o), 64'(0));
    check("rst_fetch_pc", 64'(fetch_pc_o), 64'(BOOT));
    check("rst_dec_pc", 64'(dec_pc_o), 64'(0));
    check("rst_dec_instr", 64'(dec_instr_o), 64'(0));
    q.delete();
    m_pc = BOOT;
    m_out = 1'b0;
    m_start = 1'b1;
    resp_busy = 1'b0;
    inject_done = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[11];
    int   base;
    bit   found;

    redirect_pc_i = '0;
    dec_ready_i   = 1'b1;
    n_req         = 0;
    last_req_pc   = '0;

    // Reset release, latency 2, decode always ready
    vt[0]  = '{1, 0, 32'h100, 0, 32'h0};
    vt[1]  = '{1, 1, 32'h100, 0, 32'h0};
    vt[2]  = '{1, 0, 32'h100, 0, 32'h0};
    vt[3]  = '{1, 0, 32'h100, 0, 32'h0};
    vt[4]  = '{1, 1, 32'h104, 1, 32'h100};
    vt[5]  = '{1, 0, 32'h104, 0, 32'h0};
    vt[6]  = '{1, 0, 32'h104, 0, 32'h0};
    vt[7]  = '{1, 1, 32'h108, 1, 32'h104};
    vt[8]  = '{1, 0, 32'h108, 0, 32'h0};
    vt[9]  = '{1, 0, 32'h108, 0, 32'h0};
    vt[10] = '{1, 1, 32'h10C, 1, 32'h108};

    lat = 2;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      dec_ready_i = vt[i].ready;
      settle();
      check($sformatf("vec%0d_req", i), 64'(read_req_o), 64'(vt[i].req));
      check($sformatf("vec%0d_pc", i), 64'(fetch_pc_o), 64'(vt[i].pc));
      check($sformatf("vec%0d_valid", i), 64'(dec_valid_o), 64'(vt[i].valid));
      if (vt[i].valid) check($sformatf("vec%0d_dpc", i), 64'(dec_pc_o), 64'(vt[i].dpc));
      advance();
    end

    // Backpressure: FIFO fills with four entries, then issue stops
    do_reset();
    dec_ready_i = 1'b0;
    base = n_req;
    for (int i = 0; i < 25; i++) tick();
    check("full_req_count", 64'(n_req - base), 64'(4));
    check("full_last_pc", 64'(last_req_pc), 64'(32'h10C));
    check("full_head", 64'(dec_pc_o), 64'(32'h100));
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    base = n_req;
    for (int i = 0; i < 12; i++) tick();
    check("refill_req_count", 64'(n_req - base), 64'(1));
    check("refill_pc", 64'(last_req_pc), 64'(32'h110));

    // Push and pop in the same cycle with DEPTH-1 entries queued
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    for (int k = 0; k < 20 && !done_next(); k++) tick();
    check("pp_done_ready", 64'(done_next()), 64'(1));
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    settle();
    check("pp_head", 64'(dec_pc_o), 64'(32'h10C));
    check("pp_valid", 64'(dec_valid_o), 64'(1));
    advance();

    // Redirect with a request outstanding at 0x108; late data must be ignored
    do_reset();
    dec_ready_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      settle();
      if (read_req_o && fetch_pc_o == 32'h108) found = 1'b1;
      advance();
    end
    check("find_req_108", 64'(found), 64'(1));
    redirect_i = 1'b1;
    redirect_pc_i = 32'h2003;
    settle();
    check("redir_flush", 64'(flush_o), 64'(1));
    check("redir_no_req", 64'(read_req_o), 64'(0));
    advance();
    redirect_i = 1'b0;
    inject_done = 1'b1;
    settle();
    check("redir_empty", 64'(dec_valid_o), 64'(0));
    check("redir_req", 64'(read_req_o), 64'(1));
    check("redir_pc", 64'(fetch_pc_o), 64'(32'h2000));
    advance();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      settle();
      if (dec_valid_o) begin
        found = 1'b1;
        check("redir_first_dec_pc", 64'(dec_pc_o), 64'(32'h2000));
      end
      advance();
    end
    check("redir_first_seen", 64'(found), 64'(1));

    // Redirect coinciding with read_done, then back-to-back redirects
    for (int k = 0; k < 20 && !done_next(); k++) tick();
    check("rd_done_ready", 64'(done_next()), 64'(1));
    redirect_i = 1'b1;
    redirect_pc_i = 32'h3000;
    tick();
    redirect_i = 1'b0;
    settle();
    check("rd_drop_valid", 64'(dec_valid_o), 64'(0));
    check("rd_drop_pc", 64'(fetch_pc_o), 64'(32'h3000));
    advance();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h4000;
    settle();
    check("rr1_no_req", 64'(read_req_o), 64'(0));
    advance();
    redirect_pc_i = 32'h5009;
    settle();
    check("rr2_no_req", 64'(read_req_o), 64'(0));
    advance();
    redirect_i = 1'b0;
    settle();
    check("rr_req", 64'(read_req_o), 64'(1));
    check("rr_pc", 64'(fetch_pc_o), 64'(32'h5008));
    advance();

    // Reset mid-WAIT with three entries queued
    do_reset();
    dec_ready_i = 1'b0;
    for (int k = 0; k < 40 && !(q.size() == 3 && m_out); k++) tick();
    check("mid_valid_before", 64'(dec_valid_o), 64'(1));
    do_reset();
    settle();
    check("start_no_req", 64'(read_req_o), 64'(0));
    advance();
    settle();
    check("post_rst_req", 64'(read_req_o), 64'(1));
    check("post_rst_pc", 64'(fetch_pc_o), 64'(BOOT));
    advance();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      dec_ready_i   = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 29) == 0);
      redirect_pc_i = 32'($urandom);
      lat           = int'($urandom_range(1, 4));
      tick();
    end
    redirect_i = 1'b0;
    dec_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
